demux_f6_stream: RTL



---
 rtl/demux_f6_pkg.sv | 10 +
 rtl/demux_f6_slot.sv | 35 +++
 rtl/demux_f6_stream.sv | 76 +++++++
 3 files changed

// File: rtl/demux_f6_pkg.sv
// Shared constants for the registered 1-to-2 frame-aware stream demultiplexer.
package demux_f6_pkg;

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_LOCKED = 1'b1;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/demux_f6_slot.sv
// One-entry registered output slot; a load wins over a drain on the same edge.
module demux_f6_slot
    import demux_f6_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             last,
    input  logic             ready_in,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out,
    output logic             last_out,
    output logic             space
);

    assign space = !valid_out | ready_in;

    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            last_out  <= 1'b0;
        end else if (load) begin
            valid_out <= 1'b1;
            data_out  <= data;
            last_out  <= last;
        end else if (ready_in) begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_f6_stream.sv
// Registered 1-to-2 stream demux: route picked by S on a frame's first word, locked until LAST.
module demux_f6_stream
    import demux_f6_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] I,
    input  logic             I_VALID,
    input  logic             I_LAST,
    output logic             I_READY,
    input  logic             S,
    output logic [WIDTH-1:0] O0,
    output logic             O0_VALID,
    output logic             O0_LAST,
    input  logic             O0_READY,
    output logic [WIDTH-1:0] O1,
    output logic             O1_VALID,
    output logic             O1_LAST,
    input  logic             O1_READY
);

    logic state_q;
    logic sel_q;
    logic route;
    logic space0;
    logic space1;
    logic in_xfer;

    // I_READY depends only on state, S and the target slot, never on I_VALID/I_LAST.
    assign route   = (state_q == ST_LOCKED) ? sel_q : S;
    assign I_READY = (route == PORT1) ? space1 : space0;
    assign in_xfer = I_VALID & I_READY;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            sel_q   <= PORT0;
        end else if (in_xfer) begin
            if (state_q == ST_IDLE && !I_LAST) begin
                sel_q   <= S;
                state_q <= ST_LOCKED;
            end else if (state_q == ST_LOCKED && I_LAST) begin
                state_q <= ST_IDLE;
            end
        end
    end

    demux_f6_slot #(.WIDTH(WIDTH)) u_slot0 (
        .CLK       (CLK),
        .RST       (RST),
        .load      (in_xfer && route == PORT0),
        .data      (I),
        .last      (I_LAST),
        .ready_in  (O0_READY),
        .valid_out (O0_VALID),
        .data_out  (O0),
        .last_out  (O0_LAST),
        .space     (space0)
    );

    demux_f6_slot #(.WIDTH(WIDTH)) u_slot1 (
        .CLK       (CLK),
        .RST       (RST),
        .load      (in_xfer && route == PORT1),
        .data      (I),
        .last      (I_LAST),
        .ready_in  (O1_READY),
        .valid_out (O1_VALID),
        .data_out  (O1),
        .last_out  (O1_LAST),
        .space     (space1)
    );

endmodule
